mmc_sector_buffer_pp: RTL

- Parametrised two-bank (ping-pong) sector buffer between the MMC/SD transfer engine (producer) and the bus-side DMA/CPU port (consumer).
- Each bank holds one sector of P_DEPTH words of P_DATA_N bits.
- The producer fills one bank with per-byte write protection while the consumer drains the other.
- Bank ownership passes by commit/release handshakes, so the transfer engine never stalls on a half-read sector.

---
 rtl/mmc_sector_buffer_pp.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mmc_sector_buffer_pp.sv
// Two-bank ping-pong sector buffer between the MMC/SD transfer engine and the bus-side reader.
// Banks pass from writer to reader on commit and return on release, in strict alternating order.

module mmc_sector_buffer_pp_lane #(
   parameter int P_DEPTH  = 128,
   parameter int P_ADDR_N = 7
) (
   input  logic              iCLOCK,
   input  logic              iRESET,
   input  logic              we_i,
   input  logic [P_ADDR_N:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic              re_i,
   input  logic [P_ADDR_N:0] raddr_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem [0:2*P_DEPTH-1];
   logic [7:0] rdata_q;

   // Storage is deliberately left out of reset so it maps onto block RAM.
   always_ff @(posedge iCLOCK) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

module mmc_sector_buffer_pp #(
   parameter int P_DATA_N = 32,
   parameter int P_BYTE_N = P_DATA_N / 8,
   parameter int P_DEPTH  = 128,
   parameter int P_ADDR_N = 7
) (
   input  logic                iCLOCK,
   input  logic                iRESET,
   input  logic                iFLUSH,
   input  logic                iWR_REQ,
   input  logic [P_BYTE_N-1:0] iWR_MASK,
   input  logic [P_ADDR_N-1:0] iWR_ADDR,
   input  logic [P_DATA_N-1:0] iWR_DATA,
   input  logic                iWR_COMMIT,
   output logic                oWR_AVAIL,
   output logic                oWR_BANK,
   input  logic                iRD_REQ,
   input  logic [P_ADDR_N-1:0] iRD_ADDR,
   output logic                oRD_VALID,
   output logic [P_DATA_N-1:0] oRD_DATA,
   input  logic                iRD_RELEASE,
   output logic                oRD_AVAIL,
   output logic                oRD_BANK,
   output logic [1:0]          oFULL_CNT
);
   logic [1:0] full_q, full_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       rd_vld_q, rd_vld_d;
   logic [1:0] full_cnt_q, full_cnt_d;

   logic wr_free, rd_full, wr_ok, rd_ok, commit, release_b;
   logic [P_BYTE_N-1:0][7:0] wdata_lane, rdata_lane;

   assign wr_free   = ~full_q[wr_ptr_q];
   assign rd_full   = full_q[rd_ptr_q];
   assign wr_ok     = iWR_REQ & wr_free & ~iFLUSH;
   assign rd_ok     = iRD_REQ & rd_full & ~iFLUSH;
   assign commit    = iWR_COMMIT & wr_free & ~iFLUSH;
   assign release_b = iRD_RELEASE & rd_full & ~iFLUSH;

   assign oWR_AVAIL = wr_free;
   assign oWR_BANK  = wr_ptr_q;
   assign oRD_AVAIL = rd_full;
   assign oRD_BANK  = rd_ptr_q;
   assign oRD_VALID = rd_vld_q;
   assign oFULL_CNT = full_cnt_q;

   // Commit and release can never target the same bank: one needs it FREE, the other FULL.
   always_comb begin
      full_d     = full_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_vld_d   = rd_ok;
      full_cnt_d = full_cnt_q;
      if (iFLUSH) begin
         full_d     = 2'b00;
         wr_ptr_d   = 1'b0;
         rd_ptr_d   = 1'b0;
         full_cnt_d = 2'd0;
      end else begin
         if (commit) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (release_b) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
         end
         if (commit && !release_b)      full_cnt_d = full_cnt_q + 2'd1;
         else if (release_b && !commit) full_cnt_d = full_cnt_q - 2'd1;
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         full_q     <= 2'b00;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         rd_vld_q   <= 1'b0;
         full_cnt_q <= 2'd0;
      end else begin
         full_q     <= full_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_vld_q   <= rd_vld_d;
         full_cnt_q <= full_cnt_d;
      end
   end

   assign wdata_lane = iWR_DATA;

   for (genvar b = 0; b < P_BYTE_N; b++) begin : g_lane
      mmc_sector_buffer_pp_lane #(
         .P_DEPTH (P_DEPTH),
         .P_ADDR_N(P_ADDR_N)
      ) u_lane (
         .iCLOCK (iCLOCK),
         .iRESET (iRESET),
         .we_i   (wr_ok & ~iWR_MASK[b]),
         .waddr_i({wr_ptr_q, iWR_ADDR}),
         .wdata_i(wdata_lane[b]),
         .re_i   (rd_ok),
         .raddr_i({rd_ptr_q, iRD_ADDR}),
         .rdata_o(rdata_lane[b])
      );
   end

   assign oRD_DATA = rdata_lane;
endmodule
